// File: rtl/elevator_pkg.sv
// Shared types and limits for the elevator controller slice.
package elevator_pkg;

  localparam int MAX_FLOORS = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR      = 2'd3
  } elev_state_t;

endpackage

// File: rtl/elevator_request_tracker.sv
// Pending-call bitmap with set/clear and above/below/here flags relative to a query floor.
module elevator_request_tracker
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 10,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [FLOOR_W-1:0]    set_floor,
  input  logic                  clr_en,
  input  logic [FLOOR_W-1:0]    clr_floor,
  input  logic [FLOOR_W-1:0]    query_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  here
);

  logic [NUM_FLOORS-1:0] pending_nxt;

  // Clear is applied after set so a call landing on the arrival edge counts as served.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (set_en && int'(set_floor) == i) pending_nxt[i] = 1'b1;
      if (clr_en && int'(clr_floor) == i) pending_nxt[i] = 1'b0;
    end
  end

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    here      = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(query_floor)) any_above = any_above | pending[i];
      if (i < int'(query_floor)) any_below = any_below | pending[i];
      if (i == int'(query_floor)) here = pending[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

endmodule

// File: rtl/elevator_controller.sv
// Single-car LOOK elevator controller with travel/door timers and overload door hold.
//
// state        | meaning
// ST_IDLE      | parked, door closed, choosing next action
// ST_MOVE_UP   | travelling up, travel timer counting down to next floor
// ST_MOVE_DOWN | travelling down, travel timer counting down to next floor
// ST_DOOR      | door open, door timer counting down (held while overloaded)
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 10,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  over_weight,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  up_move,
  output logic                  down_move,
  output logic                  door_open,
  output logic                  stop,
  output logic                  weight_alert,
  output logic                  arrived,
  output logic                  req_error,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES) + 1;
  localparam int DOOR_W   = $clog2(DOOR_CYCLES) + 1;
  localparam logic [TRAVEL_W-1:0] TRAVEL_LOAD = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LOAD   = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]  LAST_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

  if (NUM_FLOORS < 2 || NUM_FLOORS > MAX_FLOORS) begin : g_chk_floors
    $error("elevator_controller: NUM_FLOORS must be 2..16");
  end
  if (FLOOR_W < $clog2(NUM_FLOORS) || FLOOR_W < 1) begin : g_chk_floor_w
    $error("elevator_controller: FLOOR_W too narrow for NUM_FLOORS");
  end
  if (TRAVEL_CYCLES < 1 || DOOR_CYCLES < 1) begin : g_chk_timers
    $error("elevator_controller: TRAVEL_CYCLES and DOOR_CYCLES must be >= 1");
  end

  elev_state_t         state;
  logic                dir_up;
  logic [TRAVEL_W-1:0] travel_cnt;
  logic [DOOR_W-1:0]   door_cnt;

  logic               step_up, step_down, in_range, extend;
  logic               set_en, clr_en;
  logic [FLOOR_W-1:0] query_floor;
  logic               any_above, any_below, here;

  // Flags are evaluated at the floor the car is about to reach on a step edge.
  always_comb begin
    step_up   = (state == ST_MOVE_UP)   && (travel_cnt == '0) && (current_floor != LAST_FLOOR);
    step_down = (state == ST_MOVE_DOWN) && (travel_cnt == '0) && (current_floor != '0);
    query_floor = current_floor;
    if (step_up)   query_floor = current_floor + FLOOR_W'(1);
    if (step_down) query_floor = current_floor - FLOOR_W'(1);
    in_range = 32'(req_floor) < NUM_FLOORS;
    extend   = (state == ST_DOOR) && req_valid && (req_floor == current_floor);
    set_en   = req_valid && in_range && !extend;
    clr_en   = (state == ST_IDLE || step_up || step_down) && here;
  end

  elevator_request_tracker #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .set_en      (set_en),
    .set_floor   (req_floor),
    .clr_en      (clr_en),
    .clr_floor   (query_floor),
    .query_floor (query_floor),
    .pending     (pending),
    .any_above   (any_above),
    .any_below   (any_below),
    .here        (here)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      dir_up        <= 1'b1;
      current_floor <= '0;
      travel_cnt    <= '0;
      door_cnt      <= '0;
      up_move       <= 1'b0;
      down_move     <= 1'b0;
      door_open     <= 1'b0;
      stop          <= 1'b1;
      weight_alert  <= 1'b0;
      arrived       <= 1'b0;
      req_error     <= 1'b0;
    end else begin
      arrived   <= 1'b0;
      req_error <= req_valid && !in_range;
      case (state)
        ST_IDLE: begin
          weight_alert <= over_weight;
          if (here) begin
            state     <= ST_DOOR;
            door_cnt  <= DOOR_LOAD;
            door_open <= 1'b1;
            arrived   <= 1'b1;
          end else if (!over_weight && (any_above || any_below)) begin
            travel_cnt <= TRAVEL_LOAD;
            stop       <= 1'b0;
            if ((dir_up && any_above) || (!dir_up && !any_below)) begin
              state   <= ST_MOVE_UP;
              dir_up  <= 1'b1;
              up_move <= 1'b1;
            end else begin
              state     <= ST_MOVE_DOWN;
              dir_up    <= 1'b0;
              down_move <= 1'b1;
            end
          end
        end

        ST_MOVE_UP, ST_MOVE_DOWN: begin
          weight_alert <= 1'b0;
          if (travel_cnt != '0) begin
            travel_cnt <= travel_cnt - TRAVEL_W'(1);
          end else if (!(step_up || step_down)) begin
            state     <= ST_IDLE;
            up_move   <= 1'b0;
            down_move <= 1'b0;
            stop      <= 1'b1;
          end else begin
            current_floor <= query_floor;
            if (here) begin
              state     <= ST_DOOR;
              door_cnt  <= DOOR_LOAD;
              door_open <= 1'b1;
              arrived   <= 1'b1;
              up_move   <= 1'b0;
              down_move <= 1'b0;
              stop      <= 1'b1;
            end else if (step_up ? any_above : any_below) begin
              travel_cnt <= TRAVEL_LOAD;
            end else begin
              state     <= ST_IDLE;
              up_move   <= 1'b0;
              down_move <= 1'b0;
              stop      <= 1'b1;
            end
          end
        end

        ST_DOOR: begin
          weight_alert <= over_weight;
          if (over_weight || extend) begin
            door_cnt <= DOOR_LOAD;
          end else if (door_cnt != '0) begin
            door_cnt <= door_cnt - DOOR_W'(1);
          end else begin
            state     <= ST_IDLE;
            door_open <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller (10 floors, travel 8, door 16).
module tb_elevator_controller;

  localparam int NF = 10;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic          over_weight;
  logic [FW-1:0] current_floor;
  logic          up_move, down_move, door_open, stop, weight_alert, arrived, req_error;
  logic [NF-1:0] pending;

  int tests = 0;
  int fails = 0;
  int n;

  elevator_controller #(
    .NUM_FLOORS    (NF),
    .FLOOR_W       (FW),
    .TRAVEL_CYCLES (8),
    .DOOR_CYCLES   (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_floor     (req_floor),
    .over_weight   (over_weight),
    .current_floor (current_floor),
    .up_move       (up_move),
    .down_move     (down_move),
    .door_open     (door_open),
    .stop          (stop),
    .weight_alert  (weight_alert),
    .arrived       (arrived),
    .req_error     (req_error),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [FW-1:0] f);
    req_valid = 1'b1;
    req_floor = f;
    tick();
    req_valid = 1'b0;
  endtask

  // Returns number of cycles until arrived is seen, bounded.
  task automatic wait_arrived(output int cycles);
    cycles = 0;
    while (!arrived && cycles < 300) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_floor   = '0;
    over_weight = 1'b0;
    tick();
    tick();
    check("rst_floor",   32'(current_floor), 0);
    check("rst_up",      32'(up_move),   0);
    check("rst_down",    32'(down_move), 0);
    check("rst_door",    32'(door_open), 0);
    check("rst_stop",    32'(stop),      1);
    check("rst_walert",  32'(weight_alert), 0);
    check("rst_arrived", 32'(arrived),   0);
    check("rst_reqerr",  32'(req_error), 0);
    check("rst_pending", 32'(pending),   0);
    reset = 1'b1;

    // Request floor 3 from floor 0
    request(4'd3);
    check("s1_pend", 32'(pending), 32'h008);
    check("s1_up_early", 32'(up_move), 0);
    tick();
    check("s1_up_2cyc", 32'(up_move), 1);
    check("s1_stop_mv", 32'(stop), 0);
    repeat (7) tick();
    check("s1_floor0_hold", 32'(current_floor), 0);
    tick();
    check("s1_floor1", 32'(current_floor), 1);
    repeat (8) tick();
    check("s1_floor2", 32'(current_floor), 2);
    repeat (8) tick();
    check("s1_floor3", 32'(current_floor), 3);
    check("s1_arrived", 32'(arrived), 1);
    check("s1_door", 32'(door_open), 1);
    check("s1_up_off", 32'(up_move), 0);
    check("s1_pend_clr", 32'(pending), 0);
    tick();
    check("s1_arr_pulse", 32'(arrived), 0);
    repeat (14) tick();
    check("s1_door_15", 32'(door_open), 1);
    tick();
    check("s1_door_16", 32'(door_open), 0);
    check("s1_stop", 32'(stop), 1);

    // LOOK: moving up past 5 with calls {7,2}
    request(4'd7);
    check("s2_pend7", 32'(pending), 32'h080);
    repeat (17) tick();
    check("s2_at5", 32'(current_floor), 5);
    check("s2_up", 32'(up_move), 1);
    request(4'd2);
    check("s2_pend72", 32'(pending), 32'h084);
    wait_arrived(n);
    check("s2_t_to7", 32'(n), 15);
    check("s2_at7", 32'(current_floor), 7);
    check("s2_pend2", 32'(pending), 32'h004);
    repeat (17) tick();
    check("s2_reverse", 32'(down_move), 1);
    check("s2_still7", 32'(current_floor), 7);
    wait_arrived(n);
    check("s2_t_to2", 32'(n), 40);
    check("s2_at2", 32'(current_floor), 2);
    check("s2_pend0", 32'(pending), 0);
    repeat (16) tick();
    check("s2_closed", 32'(door_open), 0);

    // Out-of-range request
    request(4'd12);
    check("s3_err", 32'(req_error), 1);
    check("s3_pend", 32'(pending), 0);
    tick();
    check("s3_err_pulse", 32'(req_error), 0);

    // Overload during door dwell
    request(4'd2);
    check("s4_pend", 32'(pending), 32'h004);
    tick();
    check("s4_door", 32'(door_open), 1);
    check("s4_arr", 32'(arrived), 1);
    check("s4_pend_clr", 32'(pending), 0);
    over_weight = 1'b1;
    repeat (40) tick();
    check("s4_ow_door", 32'(door_open), 1);
    check("s4_ow_alert", 32'(weight_alert), 1);
    over_weight = 1'b0;
    tick();
    check("s4_alert_off", 32'(weight_alert), 0);
    repeat (14) tick();
    check("s4_door_15", 32'(door_open), 1);
    tick();
    check("s4_door_16", 32'(door_open), 0);

    // Overload in IDLE blocks departure, then reset mid MOVE_DOWN
    over_weight = 1'b1;
    request(4'd0);
    check("s6_pend", 32'(pending), 32'h001);
    tick();
    check("s6_blocked", 32'(down_move), 0);
    check("s6_alert", 32'(weight_alert), 1);
    over_weight = 1'b0;
    tick();
    check("s6_down", 32'(down_move), 1);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("s6_rst_down", 32'(down_move), 0);
    check("s6_rst_stop", 32'(stop), 1);
    check("s6_rst_floor", 32'(current_floor), 0);
    check("s6_rst_pend", 32'(pending), 0);
    check("s6_rst_door", 32'(door_open), 0);
    tick();
    reset = 1'b1;

    // Door extend by a call at the current floor
    request(4'd0);
    check("s5_pend", 32'(pending), 32'h001);
    tick();
    check("s5_door", 32'(door_open), 1);
    repeat (9) tick();
    request(4'd0);
    check("s5_pend_ext", 32'(pending), 0);
    check("s5_no_arr", 32'(arrived), 0);
    repeat (15) tick();
    check("s5_door_ext", 32'(door_open), 1);
    tick();
    check("s5_door_close", 32'(door_open), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
